// File: rtl/instr_mem_fetch.sv
// Clocked instruction memory with self-initialising sweep, program-load port and
// registered request/valid fetch. Optional macro IMEM_BOUNDS_CHECK_EN adds AddrErr.
module instr_mem_fetch #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 128,
  parameter int ADDR_W    = 7,
  parameter int INIT_MODE = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [31:0]       Address,
  input  logic              Stall,
  output logic [DATA_W-1:0] Instruction,
  output logic              InstValid,
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [DATA_W-1:0] LoadData,
  output logic              InitBusy
`ifdef IMEM_BOUNDS_CHECK_EN
  ,
  output logic              AddrErr
`endif
);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_idx_p0;
  logic              accept_p0;
  logic              unused_addr;

  function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] idx);
    logic [DATA_W+1:0] prod;
    if (INIT_MODE == 0) return '0;
    prod = {{(DATA_W+2-ADDR_W){1'b0}}, idx} * (DATA_W+2)'(3);
    return prod[DATA_W-1:0];
  endfunction

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep writes one word per cycle; the edge writing the last index enters RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
    end
  end

  assign InitBusy  = (state_q == INIT);
  assign ReqReady  = (state_q == RUN) && !Stall;
  assign accept_p0 = ReqValid && ReqReady;
  assign rd_idx_p0 = Address[ADDR_W+1:2];

  // Memory has no reset; the sweep is its only initialisation, and loads are ignored during it.
  always_ff @(posedge Clk) begin
    if (state_q == INIT)
      mem[cnt_q] <= init_word(cnt_q);
    else if (LoadEn)
      mem[LoadAddr] <= LoadData;
  end

`ifdef IMEM_BOUNDS_CHECK_EN
  logic oob_p0;
  assign oob_p0      = |Address[31:ADDR_W+2];
  assign unused_addr = ^Address[1:0];

  // Stage p0 -> output register: read-before-write against a same-cycle load.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Instruction <= '0;
      InstValid   <= 1'b0;
      AddrErr     <= 1'b0;
    end else if (accept_p0) begin
      Instruction <= oob_p0 ? '0 : mem[rd_idx_p0];
      InstValid   <= 1'b1;
      AddrErr     <= oob_p0;
    end else if (!Stall) begin
      InstValid   <= 1'b0;
      AddrErr     <= 1'b0;
    end
  end
`else
  assign unused_addr = ^{Address[31:ADDR_W+2], Address[1:0]};

  // Stage p0 -> output register: read-before-write against a same-cycle load.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Instruction <= '0;
      InstValid   <= 1'b0;
    end else if (accept_p0) begin
      Instruction <= mem[rd_idx_p0];
      InstValid   <= 1'b1;
    end else if (!Stall) begin
      InstValid   <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Self-checking bench for instr_mem_fetch: scoreboarded fetches, table vectors,
// init-sweep timing, stall hold, load collision and mid-sweep reset.
module tb_instr_mem_fetch;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;

  logic              Clk;
  logic              Reset;
  logic              ReqValid;
  logic              ReqReady;
  logic [31:0]       Address;
  logic              Stall;
  logic [DATA_W-1:0] Instruction;
  logic              InstValid;
  logic              LoadEn;
  logic [ADDR_W-1:0] LoadAddr;
  logic [DATA_W-1:0] LoadData;
  logic              InitBusy;
`ifdef IMEM_BOUNDS_CHECK_EN
  logic              AddrErr;
`endif

  instr_mem_fetch #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_MODE(1)) dut (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .Address(Address), .Stall(Stall), .Instruction(Instruction), .InstValid(InstValid),
    .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData), .InitBusy(InitBusy)
`ifdef IMEM_BOUNDS_CHECK_EN
    , .AddrErr(AddrErr)
`endif
  );

  typedef struct { logic [31:0] inst; logic err; } exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] inst; logic err; } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[8];
  logic [31:0] model_mem[DEPTH];
  int          checks = 0;
  int          errors = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_init();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'(i * 3);
  endtask

  task automatic push(input logic [31:0] inst, input logic err);
    exp_t e;
    e.inst = inst;
    e.err  = err;
    sb_q.push_back(e);
  endtask

  task automatic fetch(input logic [31:0] a);
    logic [31:0] inst;
    logic        err;
    inst = model_mem[a[ADDR_W+1:2]];
    err  = 1'b0;
`ifdef IMEM_BOUNDS_CHECK_EN
    if (|a[31:ADDR_W+2]) begin
      inst = '0;
      err  = 1'b1;
    end
`endif
    push(inst, err);
    ReqValid = 1'b1;
    Address  = a;
  endtask

  task automatic count_sweep(output int n, output logic bad, input int drop_load_at);
    n   = 0;
    bad = 1'b0;
    do begin
      step();
      n++;
      if (n == drop_load_at) LoadEn = 1'b0;
      if (InitBusy && (ReqReady || InstValid)) bad = 1'b1;
    end while (InitBusy && n < 300);
  endtask

  // Scoreboard: every accepted fetch pops one expected result one cycle later.
  initial begin
    logic acc;
    exp_t e;
    forever begin
      @(posedge Clk);
      acc = ReqValid && ReqReady && Reset;
      #2;
      if (acc) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=%h required=none", Instruction);
        end else begin
          e = sb_q.pop_front();
          check("sb_inst", Instruction, e.inst);
          check("sb_valid", 32'(InstValid), 32'd1);
`ifdef IMEM_BOUNDS_CHECK_EN
          check("sb_addrerr", 32'(AddrErr), 32'(e.err));
`endif
        end
      end
    end
  end

  initial begin
    int   n;
    logic bad;

    Reset = 1'b0; ReqValid = 1'b0; Address = '0; Stall = 1'b0;
    LoadEn = 1'b0; LoadAddr = '0; LoadData = '0;
    model_init();

    vecs[0] = '{32'h0000_0000, 32'd0,   1'b0};
    vecs[1] = '{32'h0000_0004, 32'd3,   1'b0};
    vecs[2] = '{32'h0000_01FC, 32'd381, 1'b0};
    vecs[3] = '{32'h0000_000F, 32'd9,   1'b0};
    vecs[4] = '{32'h0000_0017, 32'h2008_000A, 1'b0};
`ifdef IMEM_BOUNDS_CHECK_EN
    vecs[5] = '{32'h0000_0204, 32'd0, 1'b1};
    vecs[6] = '{32'hFFFF_FFFC, 32'd0, 1'b1};
`else
    vecs[5] = '{32'h0000_0204, 32'd3,   1'b0};
    vecs[6] = '{32'hFFFF_FFFC, 32'd381, 1'b0};
`endif
    vecs[7] = '{32'h0000_0008, 32'd6, 1'b0};

    step(); step();
    check("rst_inst", Instruction, 32'd0);
    check("rst_valid", 32'(InstValid), 32'd0);
    check("rst_ready", 32'(ReqReady), 32'd0);
    check("rst_busy", 32'(InitBusy), 32'd1);
`ifdef IMEM_BOUNDS_CHECK_EN
    check("rst_addrerr", 32'(AddrErr), 32'd0);
`endif

    Reset = 1'b1;
    count_sweep(n, bad, -1);
    check("init_cycles", 32'(n), 32'd128);
    check("init_ready_low", 32'(bad), 32'd0);
    check("run_ready", 32'(ReqReady), 32'd1);

    fetch(32'h0000_000C);
    step();
    ReqValid = 1'b0;
    step();
    check("idle_valid", 32'(InstValid), 32'd0);
    check("idle_inst_hold", Instruction, 32'd9);

    fetch(32'h0000_0010);
    step();
    fetch(32'h0000_0014);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_inst", Instruction, 32'd12);
      check("stall_valid", 32'(InstValid), 32'd1);
      check("stall_ready", 32'(ReqReady), 32'd0);
    end
    Stall = 1'b0;
    step();
    ReqValid = 1'b0;
    step();

    fetch(32'h0000_0014);
    LoadEn = 1'b1; LoadAddr = 7'd5; LoadData = 32'h2008_000A;
    model_mem[5] = 32'h2008_000A;
    step();
    LoadEn = 1'b0;
    fetch(32'h0000_0014);
    step();
    ReqValid = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      push(vecs[i].inst, vecs[i].err);
      ReqValid = 1'b1;
      Address  = vecs[i].addr;
      step();
    end
    ReqValid = 1'b0;
    step();
    check("tbl_idle_valid", 32'(InstValid), 32'd0);
`ifdef IMEM_BOUNDS_CHECK_EN
    check("tbl_idle_addrerr", 32'(AddrErr), 32'd0);
`endif

    Reset = 1'b0;
    #1;
    check("async_rst_inst", Instruction, 32'd0);
    check("async_rst_busy", 32'(InitBusy), 32'd1);
    check("async_rst_ready", 32'(ReqReady), 32'd0);
    step();
    Reset = 1'b1;
    for (int i = 0; i < 60; i++) step();
    check("mid_sweep_busy", 32'(InitBusy), 32'd1);
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    LoadEn = 1'b1; LoadAddr = 7'd0; LoadData = 32'hDEAD_BEEF;
    count_sweep(n, bad, 10);
    LoadEn = 1'b0;
    check("restart_cycles", 32'(n), 32'd128);
    check("restart_ready_low", 32'(bad), 32'd0);
    model_init();
    fetch(32'h0000_0000);
    step();
    fetch(32'h0000_0014);
    step();
    ReqValid = 1'b0;
    step();
    step();

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
